controller: RTL and testbench
=============================

# controller

Microcoded-style control unit for the multicycle 16-bit CPU. It decodes the current state, the latched instruction register and the ALU flag into bus-driver enables, register load strobes, memory strobes, an ALU function select and the next state. The state register itself sits outside the block: the CPU top level loads `nextstate` into `state` on each rising `Clk`. The block is pure combinational decode.

## Interface
No parameters.
- `Clk`  in  1  system clock. Defines the cycle for the external state register. Not used internally.
- `Reset`  in  1  synchronous, active-high reset. Takes effect through `nextstate` at the next rising `Clk`.
- `IR`  in  16  latched instruction. Opcode is `IR[15:12]`; ALU function is `IR[2:0]`.
- `flag`  in  1  ALU condition flag, used by BRF.
- `state`  in  5  current state, from the external register.
- `nextstate`  out  5  state to load at the next rising `Clk`.
- `fnSel`  out  3  ALU function select. 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASS, 110 INC, 111 DEC. Value is 000 when the ALU is unused.
- `ldMAR`, `ldIR`, `ldPC`, `ldSP`, `ldMDR`, `ldReg`, `ldRegBank`  out  1 each  register load strobes.
- `TReg`, `TRegBank`, `TSP`, `TMAR`, `TPC`, `TMDR`, `TLabel`  out  1 each  tristate enables onto the single shared bus. `TLabel` drives `IR[11:0]` onto the bus.
- `MemRead`, `MemWrite`, `IRWrite`  out  1 each  memory and instruction-register write strobes.

## Operation
General rules:
- Every output not listed for a state is 0.
- At most one `T*` enable is high in any state.
- `TMAR` is reserved and tied to 0.
- Register selection within the register bank is done by the datapath from `IR`, not by this block.

State table (state number: asserted outputs -> next state):
- 0 FETCH0: TPC, ldMAR -> 1
- 1 FETCH1: MemRead, ldMDR, TPC, fnSel=110, ldReg -> 2
- 2 FETCH2: TReg, ldPC -> 3
- 3 FETCH3: TMDR, ldIR, IRWrite -> 4
- 4 DECODE: no outputs. Next state by opcode:
  - 0 ALU -> 5
  - 1 LOAD -> 8
  - 2 STORE -> 11
  - 3 JMP -> 14
  - 4 BRF -> 14 if `flag`=1, else 0
  - 5 PUSH -> 15
  - 6 POP -> 17
  - F HALT -> 20
  - any other opcode -> 0 (NOP)
- 5: TRegBank, fnSel=101, ldReg -> 6
- 6: TRegBank, fnSel=`IR[2:0]`, ldReg -> 7
- 7: TReg, ldRegBank -> 0
- 8: TRegBank, ldMAR -> 9
- 9: MemRead, ldMDR -> 10
- 10: TMDR, ldRegBank -> 0
- 11: TRegBank, ldMAR -> 12
- 12: TRegBank, ldMDR -> 13
- 13: MemWrite -> 0
- 14: TLabel, ldPC -> 0
- 15: TSP, fnSel=111, ldReg -> 16
- 16: TReg, ldSP, ldMAR -> 12 (PUSH shares the tail of STORE)
- 17: TSP, ldMAR -> 18
- 18: MemRead, ldMDR, TSP, fnSel=110, ldReg -> 19
- 19: TReg, ldSP -> 10 (POP shares the tail of LOAD)
- 20 HALT: no outputs -> 20. Left only by `Reset`.
- 21-31 (illegal): no outputs -> 0

Reset:
- `Reset`=1 overrides everything: all control outputs are 0, `fnSel`=000 and `nextstate`=0, whatever `state`, `IR` and `flag` are.
- This holds in the middle of any instruction and in HALT.

## Timing
- All outputs are combinational from `state`, `IR`, `flag` and `Reset`. There are no internal registers and no latches.
- Every output must settle within one `Clk` period.
- `IR` loaded in state 3 is first valid in state 4. No decision depends on `IR` before state 4.
- Instruction latency in cycles, counting the 5 fetch/decode cycles (states 0-4):
  - ALU 8; LOAD 8; STORE 8; JMP 6
  - BRF 6 if taken, 5 if not taken
  - PUSH 9; POP 9; NOP 5
- `flag` is sampled only in state 4.
- Reset latency: `nextstate`=0 while `Reset` is high. The external register reaches state 0 one rising `Clk` after `Reset` is asserted.

## Test plan
- `IR`=0x000F, start at state 0: state sequence 0,1,2,3,4,5,6,7,0. In state 6, `fnSel`=111. In state 7, `TReg`=`ldRegBank`=1.
- `IR`=0x4xxx at state 4: with `flag`=0 -> `nextstate`=0; with `flag`=1 -> `nextstate`=14. In state 14, `TLabel`=`ldPC`=1.
- `IR`=0x5000 from state 4: sequence 15,16,12,13,0. `fnSel`=111 in state 15; `MemWrite`=1 only in state 13.
- `IR`=0x6000 from state 4: sequence 17,18,19,10,0. `fnSel`=110 in state 18.
- `IR`=0xF000: after state 4 the state stays at 20 with all outputs 0. Asserting `Reset` gives `nextstate`=0, and the machine is in state 0 at the next edge.
- Force `state`=25: all outputs 0 and `nextstate`=0. With `Reset`=1 in state 9: `MemRead`=0 and `nextstate`=0.

Source files
------------

// File: rtl/controller_if.sv
// rtl/controller_if.sv - decode inputs and control outputs of the multicycle CPU control unit
interface controller_if;
  logic [15:0] IR;
  logic        flag;
  logic [4:0]  state;
  logic [4:0]  nextstate;
  logic [2:0]  fnSel;
  logic        ldMAR, ldIR, ldPC, ldSP, ldMDR, ldReg, ldRegBank;
  logic        TReg, TRegBank, TSP, TMAR, TPC, TMDR, TLabel;
  logic        MemRead, MemWrite, IRWrite;

  modport master (
    output IR, flag, state,
    input  nextstate, fnSel,
    input  ldMAR, ldIR, ldPC, ldSP, ldMDR, ldReg, ldRegBank,
    input  TReg, TRegBank, TSP, TMAR, TPC, TMDR, TLabel,
    input  MemRead, MemWrite, IRWrite
  );

  modport slave (
    input  IR, flag, state,
    output nextstate, fnSel,
    output ldMAR, ldIR, ldPC, ldSP, ldMDR, ldReg, ldRegBank,
    output TReg, TRegBank, TSP, TMAR, TPC, TMDR, TLabel,
    output MemRead, MemWrite, IRWrite
  );
endinterface

// File: rtl/controller.sv
// rtl/controller.sv - combinational state/opcode decode for the multicycle 16-bit CPU
module controller (
  input  logic         Clk,
  input  logic         Reset,
  controller_if.slave  bus
);

  typedef enum logic [4:0] {
    S_FETCH0 = 5'd0, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_ALU0, S_ALU1, S_ALU2,
    S_LD0, S_LD1, S_LD2,
    S_ST0, S_ST1, S_ST2,
    S_JMP,
    S_PUSH0, S_PUSH1,
    S_POP0, S_POP1, S_POP2,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_ALU = 4'h0, OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_JMP = 4'h3,
    OP_BRF = 4'h4, OP_PUSH = 4'h5, OP_POP = 4'h6, OP_HALT = 4'hF
  } opcode_e;

  localparam logic [2:0] FN_ADD  = 3'b000;
  localparam logic [2:0] FN_PASS = 3'b101;
  localparam logic [2:0] FN_INC  = 3'b110;
  localparam logic [2:0] FN_DEC  = 3'b111;

  state_e  st;
  opcode_e op;

  assign st = state_e'(bus.state);
  assign op = opcode_e'(bus.IR[15:12]);

  // The state register lives in the CPU top; only the opcode and ALU field of IR matter here.
  logic unused_inputs;
  assign unused_inputs = ^{Clk, bus.IR[11:3]};

  assign bus.TMAR = 1'b0;

  always_comb begin
    bus.nextstate = S_FETCH0;
    bus.fnSel     = FN_ADD;
    bus.ldMAR     = 1'b0;
    bus.ldIR      = 1'b0;
    bus.ldPC      = 1'b0;
    bus.ldSP      = 1'b0;
    bus.ldMDR     = 1'b0;
    bus.ldReg     = 1'b0;
    bus.ldRegBank = 1'b0;
    bus.TReg      = 1'b0;
    bus.TRegBank  = 1'b0;
    bus.TSP       = 1'b0;
    bus.TPC       = 1'b0;
    bus.TMDR      = 1'b0;
    bus.TLabel    = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    if (!Reset) begin
      case (st)
        S_FETCH0: begin bus.TPC = 1'b1; bus.ldMAR = 1'b1; bus.nextstate = S_FETCH1; end
        S_FETCH1: begin
          bus.MemRead = 1'b1; bus.ldMDR = 1'b1; bus.TPC = 1'b1;
          bus.fnSel = FN_INC; bus.ldReg = 1'b1; bus.nextstate = S_FETCH2;
        end
        S_FETCH2: begin bus.TReg = 1'b1; bus.ldPC = 1'b1; bus.nextstate = S_FETCH3; end
        S_FETCH3: begin
          bus.TMDR = 1'b1; bus.ldIR = 1'b1; bus.IRWrite = 1'b1; bus.nextstate = S_DECODE;
        end
        S_DECODE: begin
          case (op)
            OP_ALU:   bus.nextstate = S_ALU0;
            OP_LOAD:  bus.nextstate = S_LD0;
            OP_STORE: bus.nextstate = S_ST0;
            OP_JMP:   bus.nextstate = S_JMP;
            OP_BRF:   bus.nextstate = bus.flag ? S_JMP : S_FETCH0;
            OP_PUSH:  bus.nextstate = S_PUSH0;
            OP_POP:   bus.nextstate = S_POP0;
            OP_HALT:  bus.nextstate = S_HALT;
            default:  bus.nextstate = S_FETCH0;
          endcase
        end
        S_ALU0: begin
          bus.TRegBank = 1'b1; bus.fnSel = FN_PASS; bus.ldReg = 1'b1; bus.nextstate = S_ALU1;
        end
        S_ALU1: begin
          bus.TRegBank = 1'b1; bus.fnSel = bus.IR[2:0]; bus.ldReg = 1'b1; bus.nextstate = S_ALU2;
        end
        S_ALU2:  begin bus.TReg = 1'b1; bus.ldRegBank = 1'b1; bus.nextstate = S_FETCH0; end
        S_LD0:   begin bus.TRegBank = 1'b1; bus.ldMAR = 1'b1; bus.nextstate = S_LD1; end
        S_LD1:   begin bus.MemRead = 1'b1; bus.ldMDR = 1'b1; bus.nextstate = S_LD2; end
        S_LD2:   begin bus.TMDR = 1'b1; bus.ldRegBank = 1'b1; bus.nextstate = S_FETCH0; end
        S_ST0:   begin bus.TRegBank = 1'b1; bus.ldMAR = 1'b1; bus.nextstate = S_ST1; end
        S_ST1:   begin bus.TRegBank = 1'b1; bus.ldMDR = 1'b1; bus.nextstate = S_ST2; end
        S_ST2:   begin bus.MemWrite = 1'b1; bus.nextstate = S_FETCH0; end
        S_JMP:   begin bus.TLabel = 1'b1; bus.ldPC = 1'b1; bus.nextstate = S_FETCH0; end
        S_PUSH0: begin
          bus.TSP = 1'b1; bus.fnSel = FN_DEC; bus.ldReg = 1'b1; bus.nextstate = S_PUSH1;
        end
        // PUSH and POP reuse the memory tails of STORE and LOAD.
        S_PUSH1: begin
          bus.TReg = 1'b1; bus.ldSP = 1'b1; bus.ldMAR = 1'b1; bus.nextstate = S_ST1;
        end
        S_POP0:  begin bus.TSP = 1'b1; bus.ldMAR = 1'b1; bus.nextstate = S_POP1; end
        S_POP1:  begin
          bus.MemRead = 1'b1; bus.ldMDR = 1'b1; bus.TSP = 1'b1;
          bus.fnSel = FN_INC; bus.ldReg = 1'b1; bus.nextstate = S_POP2;
        end
        S_POP2:  begin bus.TReg = 1'b1; bus.ldSP = 1'b1; bus.nextstate = S_LD2; end
        S_HALT:  bus.nextstate = S_HALT;
        default: bus.nextstate = S_FETCH0;
      endcase
    end
  end

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - scoreboard bench for the CPU control unit decode
module tb_controller;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  controller_if bus();
  controller dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [24:0] exp;
    logic [4:0]  st;
    logic [15:0] ir;
    logic        rst;
  } sb_t;
  sb_t sb_q[$];

  localparam logic [16:0] B_LDMAR = 17'h1 << 16, B_LDIR = 17'h1 << 15, B_LDPC = 17'h1 << 14;
  localparam logic [16:0] B_LDSP = 17'h1 << 13, B_LDMDR = 17'h1 << 12, B_LDREG = 17'h1 << 11;
  localparam logic [16:0] B_LDRB = 17'h1 << 10, B_TREG = 17'h1 << 9, B_TRB = 17'h1 << 8;
  localparam logic [16:0] B_TSP = 17'h1 << 7, B_TPC = 17'h1 << 5;
  localparam logic [16:0] B_TMDR = 17'h1 << 4, B_TLAB = 17'h1 << 3, B_MRD = 17'h1 << 2;
  localparam logic [16:0] B_MWR = 17'h1 << 1, B_IRW = 17'h1;

  logic [24:0] dut_vec;
  assign dut_vec = {bus.nextstate, bus.fnSel,
                    bus.ldMAR, bus.ldIR, bus.ldPC, bus.ldSP, bus.ldMDR, bus.ldReg, bus.ldRegBank,
                    bus.TReg, bus.TRegBank, bus.TSP, bus.TMAR, bus.TPC, bus.TMDR, bus.TLabel,
                    bus.MemRead, bus.MemWrite, bus.IRWrite};

  // Reference: one row per state of the control table: strobes, ALU function, successor.
  function automatic logic [24:0] model(input logic rst, input logic [4:0] st,
                                        input logic [15:0] ir, input logic flg);
    logic [16:0] m;
    logic [2:0]  fn;
    int          nx;
    m = '0; fn = 3'b000; nx = 0;
    if (rst || st > 5'd20) return '0;
    case (st)
      0:  begin m = B_TPC | B_LDMAR; nx = 1; end
      1:  begin m = B_MRD | B_LDMDR | B_TPC | B_LDREG; fn = 3'b110; nx = 2; end
      2:  begin m = B_TREG | B_LDPC; nx = 3; end
      3:  begin m = B_TMDR | B_LDIR | B_IRW; nx = 4; end
      4:  begin
        case (ir[15:12])
          4'h0: nx = 5;   4'h1: nx = 8;   4'h2: nx = 11;  4'h3: nx = 14;
          4'h4: nx = flg ? 14 : 0;
          4'h5: nx = 15;  4'h6: nx = 17;  4'hF: nx = 20;
          default: nx = 0;
        endcase
      end
      5:  begin m = B_TRB | B_LDREG; fn = 3'b101; nx = 6; end
      6:  begin m = B_TRB | B_LDREG; fn = ir[2:0]; nx = 7; end
      7:  begin m = B_TREG | B_LDRB; nx = 0; end
      8:  begin m = B_TRB | B_LDMAR; nx = 9; end
      9:  begin m = B_MRD | B_LDMDR; nx = 10; end
      10: begin m = B_TMDR | B_LDRB; nx = 0; end
      11: begin m = B_TRB | B_LDMAR; nx = 12; end
      12: begin m = B_TRB | B_LDMDR; nx = 13; end
      13: begin m = B_MWR; nx = 0; end
      14: begin m = B_TLAB | B_LDPC; nx = 0; end
      15: begin m = B_TSP | B_LDREG; fn = 3'b111; nx = 16; end
      16: begin m = B_TREG | B_LDSP | B_LDMAR; nx = 12; end
      17: begin m = B_TSP | B_LDMAR; nx = 18; end
      18: begin m = B_MRD | B_LDMDR | B_TSP | B_LDREG; fn = 3'b110; nx = 19; end
      19: begin m = B_TREG | B_LDSP; nx = 10; end
      default: nx = 20;
    endcase
    return {nx[4:0], fn, m};
  endfunction

  always @(negedge Clk) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      checks++;
      if (dut_vec !== e.exp) begin
        errors++;
        $display("FAIL decode rst=%0b state=%0d IR=%h: got %h want %h",
                 e.rst, e.st, e.ir, dut_vec, e.exp);
      end
    end
  end

  task automatic step(input logic rst, input logic [4:0] st, input logic [15:0] ir,
                      input logic flg, output logic [4:0] ns);
    sb_t e;
    @(posedge Clk);
    #1;
    Reset = rst; bus.state = st; bus.IR = ir; bus.flag = flg;
    e.exp = model(rst, st, ir, flg); e.st = st; e.ir = ir; e.rst = rst;
    sb_q.push_back(e);
    @(negedge Clk);
    ns = bus.nextstate;
  endtask

  // Closes the loop through the DUT like the CPU's state register and counts cycles back to 0.
  task automatic run_instr(input logic [15:0] ir, input logic flg, input int lat);
    logic [4:0] st, ns;
    int n;
    st = 5'd0; n = 0;
    do begin
      step(1'b0, st, ir, flg, ns);
      n++;
      st = ns;
    end while (st != 5'd0 && n < 40);
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL latency IR=%h flag=%0b: got %0d cycles want %0d", ir, flg, n, lat);
    end
  endtask

  initial begin
    logic [4:0] st, ns;
    logic [15:0] ir;
    Reset = 1'b1; bus.state = '0; bus.IR = '0; bus.flag = 1'b0;

    for (int i = 0; i < 8; i++)
      step(1'b1, 5'($urandom_range(0, 31)), 16'($urandom), 1'($urandom), ns);

    run_instr(16'h000F, 1'b0, 8);
    run_instr(16'h1000 | 16'($urandom_range(0, 4095)), 1'b0, 8);
    run_instr(16'h2000 | 16'($urandom_range(0, 4095)), 1'b1, 8);
    run_instr(16'h3000 | 16'($urandom_range(0, 4095)), 1'b0, 6);
    run_instr(16'h4ABC, 1'b0, 5);
    run_instr(16'h4ABC, 1'b1, 6);
    run_instr(16'h5000, 1'b0, 9);
    run_instr(16'h6000, 1'b1, 9);
    for (int op = 7; op < 15; op++)
      run_instr({4'(op), 12'($urandom_range(0, 4095))}, 1'($urandom), 5);

    st = 5'd0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, st, 16'hF000, 1'b0, ns);
      st = ns;
    end
    checks++;
    if (st != 5'd20) begin
      errors++;
      $display("FAIL halt_hold: got state %0d want 20", st);
    end
    step(1'b1, st, 16'hF000, 1'b0, ns);
    checks++;
    if (ns != 5'd0) begin
      errors++;
      $display("FAIL halt_reset: got nextstate %0d want 0", ns);
    end
    step(1'b0, ns, 16'hF000, 1'b0, ns);

    step(1'b0, 5'd25, 16'h1234, 1'b1, ns);
    step(1'b1, 5'd9, 16'h1234, 1'b0, ns);
    checks++;
    if (ns != 5'd0 || bus.MemRead !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got nextstate %0d MemRead %0b want 0 0", ns, bus.MemRead);
    end

    for (int i = 0; i < 400; i++) begin
      ir = 16'($urandom);
      if (i % 5 == 0) ir[15:12] = 4'h4;
      step(($urandom_range(0, 15) == 0),
           (i % 3 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 20)),
           ir, 1'($urandom), ns);
    end

    repeat (3) @(posedge Clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
